// File: rtl/exe_mem_skid_reg.sv
// rtl/exe_mem_skid_reg.sv - EXE->MEM pipeline register with 2-entry skid buffer
//
// Purpose:
//   Registered EXE->MEM boundary with a valid/ready handshake. A main entry
//   drives the MEM-side outputs and a skid entry absorbs the one extra
//   transfer that EXE can launch before it sees in_ready fall. Because of the
//   skid entry, in_ready is decoded purely from the state flops and has no
//   combinational path from out_ready. flush squashes both entries.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   flush                synchronous squash of all held entries (top priority)
//   in_valid / in_ready  EXE-side handshake
//   *_in                 EXE-side fields (WB_en, MEM_R_EN, MEM_W_EN, PC,
//                        ALU_result, ST_val, Dest)
//   out_valid/out_ready  MEM-side handshake
//   WB_en, MEM_R_EN, MEM_W_EN, PC, ALU_result, ST_val, Dest
//                        registered fields of the main entry; control fields
//                        are forced to 0 while out_valid is low
//   stall_cnt            saturating count of MEM back-pressure cycles, only
//                        present when EXE_MEM_STALL_CNT_EN is defined
//
// Configuration macro: EXE_MEM_STALL_CNT_EN

module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] ST_val_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] ST_val,
    output logic [DEST_W-1:0] Dest
`ifdef EXE_MEM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // Entry layout: {WB_en, MEM_R_EN, MEM_W_EN, PC, ALU_result, ST_val, Dest}
    localparam int ENTRY_W = 3 + 3 * DATA_W + DEST_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [ENTRY_W-1:0]  main_q;
    logic [ENTRY_W-1:0]  main_d;
    logic [ENTRY_W-1:0]  skid_q;
    logic [ENTRY_W-1:0]  skid_d;
    logic [ENTRY_W-1:0]  in_entry;

    logic                in_fire;
    logic                out_fire;
    logic                load_main;
    logic                load_skid;
    logic                skid_to_main;

    logic                main_wb;
    logic                main_mr;
    logic                main_mw;

    assign in_entry = {WB_en_in, MEM_R_EN_in, MEM_W_EN_in,
                       PC_in, ALU_result_in, ST_val_in, Dest_in};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath steering
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    // Main is consumed this edge, so the new entry replaces it.
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (out_fire) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    skid_to_main = 1'b1;
                    state_d      = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush overrides everything: same-cycle transfers on either side
        // are discarded and the entry storage is left untouched.
        if (flush) begin
            state_d      = ST_EMPTY;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure decode of the state flops)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = (state_q != ST_FULL);
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (load_main) begin
            main_d = in_entry;
        end else if (skid_to_main) begin
            main_d = skid_q;
        end
        if (load_skid) begin
            skid_d = in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // ------------------------------------------------------------------
    // Output fields: data holds its last value when empty, control is
    // gated so MEM never acts on a stale entry.
    // ------------------------------------------------------------------
    assign {main_wb, main_mr, main_mw, PC, ALU_result, ST_val, Dest} = main_q;

    assign WB_en    = main_wb & out_valid;
    assign MEM_R_EN = main_mr & out_valid;
    assign MEM_W_EN = main_mw & out_valid;

`ifdef EXE_MEM_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Back-pressure counter: cycles where MEM holds off a valid entry.
    // A flush cycle is not a stall. Only rst clears it.
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// tb/tb_exe_mem_skid_reg.sv - self-checking bench for exe_mem_skid_reg
module tb_exe_mem_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] PC_in, ALU_result_in, ST_val_in;
    logic [4:0]  Dest_in;
    logic        out_valid;
    logic        out_ready;
    logic        WB_en, MEM_R_EN, MEM_W_EN;
    logic [31:0] PC, ALU_result, ST_val;
    logic [4:0]  Dest;
`ifdef EXE_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exe_mem_skid_reg #(.DATA_W(32), .DEST_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .WB_en_in      (WB_en_in),
        .MEM_R_EN_in   (MEM_R_EN_in),
        .MEM_W_EN_in   (MEM_W_EN_in),
        .PC_in         (PC_in),
        .ALU_result_in (ALU_result_in),
        .ST_val_in     (ST_val_in),
        .Dest_in       (Dest_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .WB_en         (WB_en),
        .MEM_R_EN      (MEM_R_EN),
        .MEM_W_EN      (MEM_W_EN),
        .PC            (PC),
        .ALU_result    (ALU_result),
        .ST_val        (ST_val),
        .Dest          (Dest)
`ifdef EXE_MEM_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    // {out_valid, in_ready, WB_en, MEM_R_EN, MEM_W_EN, PC, ALU_result, ST_val, Dest}
    function automatic logic [105:0] dut_vec();
        return {out_valid, in_ready, WB_en, MEM_R_EN, MEM_W_EN,
                PC, ALU_result, ST_val, Dest};
    endfunction

    task automatic check(input string name, input logic [105:0] act, input logic [105:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy,
                         input logic wb, input logic mr, input logic mw,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] st, input logic [4:0] dest);
        flush = fl; in_valid = iv; out_ready = ordy;
        WB_en_in = wb; MEM_R_EN_in = mr; MEM_W_EN_in = mw;
        PC_in = pc; ALU_result_in = alu; ST_val_in = st; Dest_in = dest;
    endtask

    // ---------------- table-driven directed vectors ----------------
    typedef struct {
        logic        fl, iv, ordy, wb, mr, mw;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        e_ov, e_ir, e_wb, e_mr, e_mw;
        logic [31:0] e_pc;
        logic [4:0]  e_dest;
    } vec_t;

    function automatic vec_t mk(input logic fl, input logic iv, input logic ordy,
                                input logic wb, input logic mr, input logic mw,
                                input logic [31:0] pc, input logic [4:0] dest,
                                input logic e_ov, input logic e_ir, input logic e_wb,
                                input logic e_mr, input logic e_mw,
                                input logic [31:0] e_pc, input logic [4:0] e_dest);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.wb = wb; v.mr = mr; v.mw = mw;
        v.pc = pc; v.dest = dest;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_wb = e_wb; v.e_mr = e_mr; v.e_mw = e_mw;
        v.e_pc = e_pc; v.e_dest = e_dest;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        wb, mr, mw;
        logic [31:0] pc, alu, st;
        logic [4:0]  dest;
    } entry_t;

    entry_t      mq[$];
    entry_t      m_last;
    logic [31:0] m_stall;

    function automatic logic [105:0] model_vec();
        entry_t h;
        logic   ov;
        ov = (mq.size() > 0);
        h  = ov ? mq[0] : m_last;
        return {ov, (mq.size() < 2), h.wb & ov, h.mr & ov, h.mw & ov,
                h.pc, h.alu, h.st, h.dest};
    endfunction

    vec_t tbl[18];

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        check("reset_state", dut_vec(), {2'b01, 104'd0});
        rst = 1'b0;

        // Stream
        tbl[0]  = mk(0,1,1, 1,0,0, 32'h100, 5'd1,  1,1,1,0,0, 32'h100, 5'd1);
        tbl[1]  = mk(0,1,1, 1,0,0, 32'h104, 5'd2,  1,1,1,0,0, 32'h104, 5'd2);
        tbl[2]  = mk(0,1,1, 1,0,0, 32'h108, 5'd3,  1,1,1,0,0, 32'h108, 5'd3);
        tbl[3]  = mk(0,0,1, 0,0,0, 32'h0,   5'd0,  0,1,0,0,0, 32'h108, 5'd3);
        // Backpressure: A(Dest=3), B(Dest=7), refused C, then drain
        tbl[4]  = mk(0,1,0, 0,0,1, 32'h200, 5'd3,  1,1,0,0,1, 32'h200, 5'd3);
        tbl[5]  = mk(0,1,0, 1,0,0, 32'h204, 5'd7,  1,0,0,0,1, 32'h200, 5'd3);
        tbl[6]  = mk(0,1,0, 1,1,1, 32'h208, 5'd9,  1,0,0,0,1, 32'h200, 5'd3);
        tbl[7]  = mk(0,0,1, 0,0,0, 32'h0,   5'd0,  1,1,1,0,0, 32'h204, 5'd7);
        tbl[8]  = mk(0,0,1, 0,0,0, 32'h0,   5'd0,  0,1,0,0,0, 32'h204, 5'd7);
        // Flush from FULL with C offered and MEM ready
        tbl[9]  = mk(0,1,0, 1,0,1, 32'h300, 5'd4,  1,1,1,0,1, 32'h300, 5'd4);
        tbl[10] = mk(0,1,0, 1,0,1, 32'h304, 5'd5,  1,0,1,0,1, 32'h300, 5'd4);
        tbl[11] = mk(1,1,1, 1,0,1, 32'h308, 5'd6,  0,1,0,0,0, 32'h300, 5'd4);
        tbl[12] = mk(0,0,1, 0,0,0, 32'h0,   5'd0,  0,1,0,0,0, 32'h300, 5'd4);
        // Flush from ONE with in_valid
        tbl[13] = mk(0,1,0, 0,1,0, 32'h400, 5'd8,  1,1,0,1,0, 32'h400, 5'd8);
        tbl[14] = mk(1,1,0, 0,1,0, 32'h404, 5'd10, 0,1,0,0,0, 32'h400, 5'd8);
        tbl[15] = mk(0,0,0, 0,0,0, 32'h0,   5'd0,  0,1,0,0,0, 32'h400, 5'd8);
        // Control gating on drain
        tbl[16] = mk(0,1,1, 0,0,1, 32'h500, 5'd11, 1,1,0,0,1, 32'h500, 5'd11);
        tbl[17] = mk(0,0,1, 0,0,0, 32'h0,   5'd0,  0,1,0,0,0, 32'h500, 5'd11);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].wb, tbl[i].mr, tbl[i].mw,
                  tbl[i].pc, tbl[i].pc + 32'd1, tbl[i].pc + 32'd2, tbl[i].dest);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dut_vec(),
                  {tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_wb, tbl[i].e_mr, tbl[i].e_mw,
                   tbl[i].e_pc, tbl[i].e_pc + 32'd1, tbl[i].e_pc + 32'd2, tbl[i].e_dest});
        end

        // Asynchronous reset in FULL, mid-cycle, no clock edge
        @(negedge clk);
        drive(0, 1, 0, 1, 1, 1, 32'h600, 32'h601, 32'h602, 5'd12);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 1, 1, 1, 32'h604, 32'h605, 32'h606, 5'd13);
        @(posedge clk);
        #1;
        check("full_before_reset", {out_valid, in_ready}, {1'b1, 1'b0});
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", dut_vec(), {2'b01, 104'd0});
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef EXE_MEM_STALL_CNT_EN
        // 9 stall cycles, then a flush cycle that is not counted
        check32("stall_after_reset", stall_cnt, 32'd0);
        drive(0, 1, 0, 1, 0, 0, 32'h700, 32'h701, 32'h702, 5'd14);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            flush = (i == 9);
            @(negedge clk);
        end
        flush = 1'b0;
        check32("stall_cnt_9", stall_cnt, 32'd9);
        check("stall_flushed", {out_valid, in_ready}, {1'b0, 1'b1});
        @(negedge clk);
        check32("stall_kept_after_flush", stall_cnt, 32'd9);
`endif

        // Randomised run against the queue model
        rst = 1'b1;
        #1;
        rst = 1'b0;
        mq.delete();
        m_last  = '0;
        m_stall = 32'd0;
        for (int c = 0; c < 800; c++) begin
            logic   fl, iv, ordy, ov, ir;
            entry_t e;
            int     phase;
            @(negedge clk);
            phase = (c / 100) % 4;
            fl   = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = (phase == 0) ? ($urandom_range(0, 3) != 0) :
                   (phase == 1) ? ($urandom_range(0, 3) == 0) :
                   (phase == 2) ? 1'b1 : $urandom_range(0, 1);
            e.wb = $urandom_range(0, 1); e.mr = $urandom_range(0, 1); e.mw = $urandom_range(0, 1);
            e.pc = $urandom; e.alu = $urandom; e.st = $urandom;
            e.dest = 5'($urandom_range(0, 31));
            drive(fl, iv, ordy, e.wb, e.mr, e.mw, e.pc, e.alu, e.st, e.dest);

            ov = (mq.size() > 0);
            ir = (mq.size() < 2);
            if (ov && !ordy && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (fl) begin
                mq.delete();
            end else begin
                if (ov && ordy) void'(mq.pop_front());
                if (iv && ir) mq.push_back(e);
            end
            if (mq.size() > 0) m_last = mq[0];

            @(posedge clk);
            #1;
            check($sformatf("rand%0d", c), dut_vec(), model_vec());
`ifdef EXE_MEM_STALL_CNT_EN
            check32($sformatf("rand_stall%0d", c), stall_cnt, m_stall);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
